// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-issue load/store unit sitting after the EX stage. An accepted op is
//   either passed straight to writeback (neither load nor store), turned into
//   one memory request (valid load/store), or rejected with an error pulse.
//   Completion is always signalled by a single-cycle pulse on wb_valid or err,
//   never both.
//
//   Optional feature (compile-time macro LSU_MISALIGN_TRAP_EN):
//     defined   - misaligned halfword/word accesses trap with err_code 01.
//     undefined - offending low address bits are cleared and the access runs.
//
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   : op handshake from EX; in_ready high only in IDLE
//   alu_result            : effective address or pass-through value
//   store_data            : rs2 value for stores
//   funct3                : access size / signedness
//   is_load, is_store     : op kind (both set is treated as a load)
//   rd                    : destination register
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request (held stable)
//   mem_ready, mem_rdata  : memory completion and read word
//   wb_valid/wb_we/wb_rd/wb_data : one-cycle writeback pulse
//   err, err_code         : one-cycle fault pulse; 01 misalign, 10 timeout,
//                           11 bad funct3
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Captured op context needed when the memory response returns.
  logic          op_load;
  logic [2:0]    op_funct3;
  logic [1:0]    op_off;
  logic [4:0]    op_rd;

  // Decode of the op currently offered on the input side.
  logic          f3_ok;
  logic          size_half;
  logic          size_word;
  logic          trap;
  logic [1:0]    eff_off;
  logic [3:0]    st_strb;
  logic [31:0]   st_wdata;

  // Load extraction from the returned word.
  logic [7:0]    rd_bytes [4];
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_data;

  assign in_ready = (state == IDLE);

  // Valid codes share the size encoding in funct3[1:0]: 00 byte, 01 half, 10 word.
  assign size_half = (funct3[1:0] == 2'b01);
  assign size_word = (funct3[1:0] == 2'b10);

  always_comb begin
    f3_ok = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (size_half & alu_result[0]) |
                (size_word & (alu_result[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Byte offset actually used for lanes. In trap mode a misaligned access never
  // reaches memory, so clearing the bits here is only visible in non-trap mode.
  always_comb begin
    eff_off = alu_result[1:0];
    if (size_half) eff_off[0] = 1'b0;
    if (size_word) eff_off    = 2'b00;
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = store_data;
    if (size_half) begin
      st_strb  = 4'b0011 << eff_off;
      st_wdata = {2{store_data[15:0]}};
    end else if (!size_word) begin
      st_strb  = 4'b0001 << eff_off;
      st_wdata = {4{store_data[7:0]}};
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_bytes[gi] = mem_rdata[8*gi +: 8];
  end

  assign ld_byte = rd_bytes[op_off];
  assign ld_half = {rd_bytes[{op_off[1], 1'b1}], rd_bytes[{op_off[1], 1'b0}]};

  always_comb begin
    case (op_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_load   <= 1'b0;
      op_funct3 <= 3'b000;
      op_off    <= 2'b00;
      op_rd     <= 5'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      // Both completion signals are pulses; they are only raised on the
      // transition into WB.
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_load   <= is_load;
            op_funct3 <= funct3;
            op_off    <= eff_off;
            op_rd     <= rd;
            wait_cnt  <= '0;
            state     <= WB;
            if (!is_load && !is_store) begin
              wb_valid <= 1'b1;
              wb_we    <= (rd != 5'd0);
              wb_rd    <= rd;
              wb_data  <= alu_result;
            end else if (!f3_ok) begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end else if (trap) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state     <= MEM;
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_wdata <= is_load ? 32'd0 : st_wdata;
              mem_wstrb <= is_load ? 4'd0 : st_strb;
            end
          end
        end
        MEM: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'd0;
            wb_valid  <= 1'b1;
            wb_we     <= op_load && (op_rd != 5'd0);
            wb_rd     <= op_rd;
            wb_data   <= op_load ? load_data : 32'd0;
            state     <= WB;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // This cycle's increment brings the count to TIMEOUT_CYCLES.
            if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_wstrb <= 4'd0;
              err       <= 1'b1;
              err_code  <= 2'b10;
              state     <= WB;
            end
          end
        end
        WB: begin
          wb_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an expected-completion queue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  funct3 = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [4:0]  rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
    .is_load(is_load), .is_store(is_store), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .err_code(err_code)
  );

  typedef struct {
    logic        is_err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic [1:0]  code;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic we, input logic [4:0] r, input logic [31:0] d, input logic cd);
    exp_t e;
    e.is_err = 1'b0; e.we = we; e.rd = r; e.data = d; e.chk_data = cd; e.code = 2'b00;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.we = 1'b0; e.rd = 5'd0; e.data = 32'd0; e.chk_data = 1'b0; e.code = c;
    sb_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    alu_result = a; store_data = sd; rd = r;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input logic we, input logic [31:0] a, input logic [3:0] s);
    chk({tag, "_req"}, mem_req, 1'b1);
    chk({tag, "_we"}, mem_we, we);
    chk({tag, "_addr"}, mem_addr, a);
    if (we) chk({tag, "_strb"}, mem_wstrb, s);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("mem_req_hold", mem_req, 1'b1);
    end
  endtask

  task automatic complete(input logic [31:0] w);
    mem_ready = 1'b1; mem_rdata = w;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic to_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", in_ready, 1'b1);
  endtask

  // Completion monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && (wb_valid || err)) begin
      chk("wb_err_exclusive", {31'd0, wb_valid & err}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, wb_valid, err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_err) begin
          chk("err", err, 1'b1);
          chk("err_code", err_code, mon_e.code);
        end else begin
          chk("wb_valid", wb_valid, 1'b1);
          chk("wb_we", wb_we, mon_e.we);
          chk("wb_rd", wb_rd, mon_e.rd);
          if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", mem_wstrb, 4'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Pass-through, one cycle latency
    push_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd5);
    chk("pt_latency", wb_valid, 1'b1);
    chk("pt_busy", in_ready, 1'b0);
    to_idle();
    // Pass-through to x0: no register write; funct3 is irrelevant
    push_wb(1'b0, 5'd0, 32'hCAFE_0000, 1'b1);
    issue(1'b0, 1'b0, 3'b111, 32'hCAFE_0000, 32'd0, 5'd0);
    to_idle();

    // SB at 0x103
    push_wb(1'b0, 5'd3, 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd3);
    chk_mem("sb", 1'b1, 32'h0000_0100, 4'b1000);
    chk("sb_wdata_hi", {24'd0, mem_wdata[31:24]}, 32'h0000_00AB);
    wait_cycles(2);
    chk_mem("sb_stable", 1'b1, 32'h0000_0100, 4'b1000);
    complete(32'd0);
    to_idle();

    // SH at 0x002, SW at 0x008
    push_wb(1'b0, 5'd4, 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_5678, 5'd4);
    chk_mem("sh", 1'b1, 32'h0000_0000, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h5678_5678);
    complete(32'd0);
    to_idle();
    push_wb(1'b0, 5'd6, 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 5'd6);
    chk_mem("sw", 1'b1, 32'h0000_0008, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    complete(32'd0);
    to_idle();

    // LB / LBU at 0x202
    push_wb(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1);
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'd0, 5'd7);
    chk_mem("lb", 1'b0, 32'h0000_0200, 4'd0);
    complete(32'h0080_0000);
    to_idle();
    push_wb(1'b1, 5'd8, 32'h0000_0080, 1'b1);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'd0, 5'd8);
    wait_cycles(1);
    complete(32'h0080_0000);
    to_idle();

    // LH / LHU at 0x102, LW at 0x010
    push_wb(1'b1, 5'd9, 32'hFFFF_8001, 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 5'd9);
    complete(32'h8001_0000);
    to_idle();
    push_wb(1'b1, 5'd9, 32'h0000_8001, 1'b1);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 5'd9);
    complete(32'h8001_0000);
    to_idle();
    push_wb(1'b1, 5'd31, 32'h1234_5678, 1'b1);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd31);
    chk_mem("lw", 1'b0, 32'h0000_0010, 4'd0);
    complete(32'h1234_5678);
    to_idle();
    // Load into x0: completes without register write
    push_wb(1'b0, 5'd0, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 5'd0);
    complete(32'h5555_AAAA);
    to_idle();

    // Load and store both set: behaves as LBU at lane 1
    push_wb(1'b1, 5'd12, 32'h0000_00F1, 1'b1);
    issue(1'b1, 1'b1, 3'b100, 32'h0000_0301, 32'hFFFF_FFFF, 5'd12);
    chk_mem("ldst", 1'b0, 32'h0000_0300, 4'd0);
    complete(32'h0000_F100);
    to_idle();

    // Illegal funct3: error 11, no memory request
    push_err(2'b11);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'd0, 5'd4);
    chk("bad_ld_noreq", mem_req, 1'b0);
    to_idle();
    push_err(2'b11);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'd0, 5'd4);
    chk("bad_st_noreq", mem_req, 1'b0);
    to_idle();

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    push_err(2'b01);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 5'd10);
    chk("mis_lw_noreq", mem_req, 1'b0);
    to_idle();
    push_err(2'b01);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 5'd11);
    chk("mis_lh_noreq", mem_req, 1'b0);
    to_idle();
    push_err(2'b01);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 5'd11);
    chk("mis_sh_noreq", mem_req, 1'b0);
    to_idle();
`else
    push_wb(1'b1, 5'd10, 32'h1122_3344, 1'b1);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 5'd10);
    chk_mem("mis_lw", 1'b0, 32'h0000_0004, 4'd0);
    complete(32'h1122_3344);
    to_idle();
    push_wb(1'b1, 5'd11, 32'hFFFF_AABB, 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 5'd11);
    complete(32'hAABB_CCDD);
    to_idle();
    push_wb(1'b0, 5'd11, 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 5'd11);
    chk_mem("mis_sh", 1'b1, 32'h0000_0000, 4'b0011);
    chk("mis_sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    complete(32'd0);
    to_idle();
`endif

    // Timeout after 4 wait cycles
    push_err(2'b10);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd12);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 32'd4);
    chk("timeout_err_now", err, 1'b1);
    to_idle();

    // mem_ready while no request is outstanding is ignored
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("stray_ready_wb", wb_valid, 1'b0);
    mem_ready = 1'b0; mem_rdata = 32'd0;

    // Reset in MEM discards the op
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, 5'd13);
    wait_cycles(1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    chk("rst_mid_wb", wb_valid, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    repeat (6) @(negedge clk);

    // Recovery after reset
    push_wb(1'b1, 5'd1, 32'h0000_0077, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'd0, 5'd1);
    to_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum memory wait cycles before abort.
REQ-002 The block SHALL have these ports (clock and reset first); clock is clk, single clock; reset is reset, synchronous, active-high:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous active-high reset
- in_valid  in  1  EX stage offers an op
- in_ready  out  1  block can accept an op
- alu_result  in  32  ALU output: effective address, or pass-through value
- store_data  in  32  rs2 value for stores
- funct3  in  3  access size/signedness
- is_load  in  1  op is a load
- is_store  in  1  op is a store
- rd  in  5  destination register
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes
- mem_ready  in  1  memory completes request
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  register write enable
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- err  out  1  one-cycle fault pulse
- err_code  out  2  01 misaligned, 10 timeout, 11 bad funct3

Function
REQ-003 The FSM SHALL have states IDLE, MEM, WB; in_ready = 1 only in IDLE.
REQ-004 Accept = in_valid & in_ready; the block SHALL capture all inputs on accept.
REQ-005 If is_load and is_store are both 0, the block SHALL go to WB: wb_data = alu_result, wb_we = (rd != 0), one cycle after accept.
REQ-006 If both are 1, the block SHALL treat the op as a load.
REQ-007 Load/store decoding SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code gives err_code 11 with no memory access.
REQ-008 Valid memory op: the block SHALL go to MEM and hold mem_req = 1 from the cycle after accept until mem_ready is sampled 1, with mem_addr, mem_we, mem_wdata and mem_wstrb stable.
REQ-009 mem_addr SHALL equal {alu_result[31:2], 2'b00}.
REQ-010 Store strobes SHALL be: SB 4'b0001 << a[1:0]; SH 4'b0011 << a[1:0]; SW 4'b1111; mem_wdata = store_data replicated into the selected lanes.
REQ-011 Loads SHALL extract the byte/halfword at a[1:0] from mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-012 On mem_ready = 1 in MEM, the block SHALL go to WB next cycle; loads: wb_we = (rd != 0); stores: wb_we = 0.
REQ-013 In WB, wb_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; minimum throughput is one op per 2 cycles (pass-through).
REQ-014 A wait counter SHALL increment each MEM cycle with mem_ready = 0; on reaching TIMEOUT_CYCLES the block SHALL drop mem_req, pulse err with code 10, skip writeback, and return to IDLE.
REQ-015 On any error, wb_valid SHALL stay 0 and err SHALL pulse 1 cycle; err and wb_valid SHALL never assert together.
REQ-016 A mem_ready arriving in a cycle where mem_req = 0 SHALL be ignored.

Reset
REQ-017 Reset SHALL take priority over all other inputs; any in-flight op is discarded.
REQ-018 On reset: state IDLE, counter 0.
REQ-019 Output values during and after reset: in_ready = 1 after the reset cycle; mem_req, mem_we, wb_valid, wb_we and err = 0; mem_addr, mem_wdata, wb_data = 0; mem_wstrb = 0; wb_rd = 0; err_code = 00.

Configuration
REQ-020 Macro LSU_MISALIGN_TRAP_EN, when defined: a halfword access with a[0] = 1, or a word access with a[1:0] != 0, SHALL pulse err with code 01 one cycle after accept, with no memory access.
REQ-021 Macro LSU_MISALIGN_TRAP_EN, when not defined: offending low address bits SHALL be forced to 0 (halfword a[0] = 0; word a[1:0] = 00), the access proceeds, and err_code 01 never occurs.

Verification
REQ-022 Pass-through: alu_result = 0x0000_1234, rd = 5, no load/store -> wb_valid 1 cycle after accept, wb_data = 0x1234, wb_we = 1.
REQ-023 SB: addr 0x103, store_data 0xAB -> mem_addr 0x100, mem_wstrb 4'b1000, mem_wdata[31:24] = 0xAB, wb_we = 0 after mem_ready.
REQ-024 LB vs LBU: addr 0x202, mem_rdata 0x0080_0000 -> LB gives wb_data 0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-025 Timeout: TIMEOUT_CYCLES = 4, mem_ready held 0 -> mem_req drops after 4 wait cycles, err = 1, err_code = 10, no wb_valid.
REQ-026 LW at addr 0x006: with LSU_MISALIGN_TRAP_EN -> err_code 01, mem_req never asserts; without it -> mem_addr 0x004, load completes.
REQ-027 Reset mid-op: assert reset while in MEM -> next cycle mem_req = 0, in_ready = 1, no wb_valid or err pulse.
